// File: rtl/gray_code_converter.sv
// ============================================================================
// gray_code_converter : registered binary->Gray->binary round trip with check
// Rev 1.0
// ============================================================================
`default_nettype none

module gray_code_converter #(
   parameter int DWIDTH = 3
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   input  logic [DWIDTH-1:0] i_data,
   output logic              o_valid_gray,
   output logic [DWIDTH-1:0] o_data_gray,
   output logic              o_valid_bin,
   output logic [DWIDTH-1:0] o_data_bin,
   output logic              o_err
);

   function automatic logic [DWIDTH-1:0] bin2gray(input logic [DWIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Prefix XOR from the MSB down; purely combinational.
   function automatic logic [DWIDTH-1:0] gray2bin(input logic [DWIDTH-1:0] g);
      logic [DWIDTH-1:0] b;
      b[DWIDTH-1] = g[DWIDTH-1];
      for (int k = DWIDTH - 2; k >= 0; k--) begin
         b[k] = b[k+1] ^ g[k];
      end
      return b;
   endfunction

   logic              valid_gray_q, valid_gray_d;
   logic [DWIDTH-1:0] gray_q, gray_d;
   logic [DWIDTH-1:0] bin_s1_q, bin_s1_d;
   logic              valid_bin_q, valid_bin_d;
   logic [DWIDTH-1:0] bin_q, bin_d;
   logic              err_q, err_d;
   logic [DWIDTH-1:0] w_dec;

   assign w_dec = gray2bin(gray_q);

   // Data registers only load on a valid beat, so X on idle inputs never leaks.
   always_comb begin
      valid_gray_d = i_valid;
      gray_d       = gray_q;
      bin_s1_d     = bin_s1_q;
      if (i_valid) begin
         gray_d   = bin2gray(i_data);
         bin_s1_d = i_data;
      end
   end

   always_comb begin
      valid_bin_d = valid_gray_q;
      bin_d       = bin_q;
      err_d       = 1'b0;
      if (valid_gray_q) begin
         bin_d = w_dec;
         err_d = (w_dec != bin_s1_q);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         valid_gray_q <= 1'b0;
         gray_q       <= '0;
         bin_s1_q     <= '0;
         valid_bin_q  <= 1'b0;
         bin_q        <= '0;
         err_q        <= 1'b0;
      end else begin
         valid_gray_q <= valid_gray_d;
         gray_q       <= gray_d;
         bin_s1_q     <= bin_s1_d;
         valid_bin_q  <= valid_bin_d;
         bin_q        <= bin_d;
         err_q        <= err_d;
      end
   end

   assign o_valid_gray = valid_gray_q;
   assign o_data_gray  = gray_q;
   assign o_valid_bin  = valid_bin_q;
   assign o_data_bin   = bin_q;
   assign o_err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_gray_code_converter.sv
// ============================================================================
// tb_gray_code_converter : scoreboard bench for gray_code_converter (DWIDTH=3)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_gray_code_converter;

   localparam int DWIDTH = 3;

   logic              i_clk = 1'b0;
   logic              i_rst = 1'b1;
   logic              i_valid = 1'b0;
   logic [DWIDTH-1:0] i_data = '0;
   logic              o_valid_gray;
   logic [DWIDTH-1:0] o_data_gray;
   logic              o_valid_bin;
   logic [DWIDTH-1:0] o_data_bin;
   logic              o_err;

   gray_code_converter #(.DWIDTH(DWIDTH)) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_valid      (i_valid),
      .i_data       (i_data),
      .o_valid_gray (o_valid_gray),
      .o_data_gray  (o_data_gray),
      .o_valid_bin  (o_valid_bin),
      .o_data_bin   (o_data_bin),
      .o_err        (o_err)
   );

   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DWIDTH-1:0] gray_q_exp[$];
   logic [DWIDTH-1:0] bin_q_exp[$];
   logic              vg_exp = 1'b0;
   logic              vb_exp = 1'b0;
   logic [DWIDTH-1:0] last_gray = '0;
   logic [DWIDTH-1:0] last_bin  = '0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Reference encoder written bit by bit from the Gray definition.
   function automatic logic [DWIDTH-1:0] enc_model(input logic [DWIDTH-1:0] b);
      logic [DWIDTH-1:0] g;
      g[DWIDTH-1] = b[DWIDTH-1];
      for (int k = 0; k < DWIDTH - 1; k++) g[k] = b[k+1] ^ b[k];
      return g;
   endfunction

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_vg"},  {31'd0, o_valid_gray}, 32'd0);
      check_eq({tag, "_g"},   {29'd0, o_data_gray},  32'd0);
      check_eq({tag, "_vb"},  {31'd0, o_valid_bin},  32'd0);
      check_eq({tag, "_b"},   {29'd0, o_data_bin},   32'd0);
      check_eq({tag, "_err"}, {31'd0, o_err},        32'd0);
   endtask

   // Drive one beat, advance one clock, then compare outputs against the scoreboard.
   task automatic step(input logic v, input logic [DWIDTH-1:0] d, input logic [DWIDTH-1:0] g_exp);
      i_valid = v;
      i_data  = v ? d : 'x;
      if (v) begin
         gray_q_exp.push_back(g_exp);
         bin_q_exp.push_back(d);
      end
      @(posedge i_clk);
      #1;
      vb_exp = vg_exp;
      vg_exp = v;
      check_eq("valid_gray", {31'd0, o_valid_gray}, {31'd0, vg_exp});
      check_eq("valid_bin",  {31'd0, o_valid_bin},  {31'd0, vb_exp});
      if (vg_exp) begin
         if (gray_q_exp.size() == 0) check_eq("gray_queue_empty", 32'd0, 32'd1);
         else last_gray = gray_q_exp.pop_front();
      end
      check_eq("data_gray", {29'd0, o_data_gray}, {29'd0, last_gray});
      if (vb_exp) begin
         if (bin_q_exp.size() == 0) check_eq("bin_queue_empty", 32'd0, 32'd1);
         else last_bin = bin_q_exp.pop_front();
      end
      check_eq("data_bin", {29'd0, o_data_bin}, {29'd0, last_bin});
      check_eq("err", {31'd0, o_err}, 32'd0);
   endtask

   task automatic clear_model();
      gray_q_exp.delete();
      bin_q_exp.delete();
      vg_exp    = 1'b0;
      vb_exp    = 1'b0;
      last_gray = '0;
      last_bin  = '0;
   endtask

   logic [DWIDTH-1:0] sweep_gray [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                                         3'b110, 3'b111, 3'b101, 3'b100};
   logic [DWIDTH-1:0] spot_in    [4] = '{3'b101, 3'b010, 3'b111, 3'b100};
   logic [DWIDTH-1:0] spot_gray  [4] = '{3'b111, 3'b011, 3'b100, 3'b110};

   initial begin
      logic [DWIDTH-1:0] r;

      // Reset held with i_valid toggling.
      #1;
      check_all_zero("rst_t0");
      for (int i = 0; i < 4; i++) begin
         i_valid = ~i_valid;
         i_data  = 3'(i + 5);
         @(posedge i_clk);
         #1;
         check_all_zero("rst_hold");
      end
      i_valid = 1'b0;
      @(negedge i_clk);
      i_rst = 1'b0;
      clear_model();
      step(1'b0, '0, '0);
      step(1'b0, '0, '0);

      // Full sweep 0..7 against literal Gray table.
      for (int i = 0; i < 8; i++) step(1'b1, 3'(i), sweep_gray[i]);

      // Spot values.
      for (int i = 0; i < 4; i++) step(1'b1, spot_in[i], spot_gray[i]);

      // Gaps: 6, idle, idle, 3.
      step(1'b1, 3'd6, 3'b101);
      step(1'b0, '0, '0);
      step(1'b0, '0, '0);
      step(1'b1, 3'd3, 3'b010);
      step(1'b0, '0, '0);
      step(1'b0, '0, '0);

      // Mid-stream reset with two words in flight.
      step(1'b1, 3'd5, 3'b111);
      step(1'b1, 3'd2, 3'b011);
      check_eq("inflight_vg", {31'd0, o_valid_gray}, 32'd1);
      check_eq("inflight_vb", {31'd0, o_valid_bin},  32'd1);
      i_valid = 1'b0;
      i_data  = 'x;
      #2;
      i_rst = 1'b1;
      #1;
      check_all_zero("async_rst");
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      clear_model();
      for (int i = 0; i < 3; i++) step(1'b0, '0, '0);

      // Random traffic.
      for (int i = 0; i < 100; i++) begin
         r = 3'($urandom_range(0, 7));
         step(1'b1, r, enc_model(r));
      end
      step(1'b0, '0, '0);
      step(1'b0, '0, '0);
      check_eq("gray_queue_drained", gray_q_exp.size(), 32'd0);
      check_eq("bin_queue_drained",  bin_q_exp.size(),  32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
